// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop sync, stable-count filter, press/release/long pulses.
// Latency key_in->key_state is 2+DURATION cycles; no backpressure, all outputs registered.
module key_debounce_multi #(
  parameter int NUM_KEYS      = 4,
  parameter bit ACTIVE_LEVEL  = 1'b1,
  parameter int DURATION      = 600,
  parameter int CNT_WIDTH     = 12,
  parameter int LONG_DURATION = 50000000,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int LONG_WIDTH    = 26
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam logic [CNT_WIDTH-1:0]  DEB_LAST  = CNT_WIDTH'(DURATION - 1);
  localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_DURATION - 1);
  localparam logic [LONG_WIDTH-1:0] REP_LAST  = LONG_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic                  IDLE_LVL  = ~ACTIVE_LEVEL;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_state;
    logic                  r_press;
    logic                  r_release;
    logic                  r_long;
    logic [LONG_WIDTH-1:0] r_hold;
    logic                  r_fired;
    logic                  w_raw;
    logic                  w_flip;
    logic                  w_hit;

    assign w_raw  = ~(r_sync2 ^ ACTIVE_LEVEL);
    assign w_flip = (w_raw != r_state) && (r_cnt == DEB_LAST);
    // Once fired, a non-repeating channel parks its hold counter and never hits again.
    assign w_hit  = r_state && (r_fired ? (REPEAT_EN && (r_hold == REP_LAST))
                                        : (r_hold == LONG_LAST));

    always_ff @(posedge mclk) begin
      if (rst) begin
        r_sync1   <= IDLE_LVL;
        r_sync2   <= IDLE_LVL;
        r_cnt     <= '0;
        r_state   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_hold    <= '0;
        r_fired   <= 1'b0;
      end else begin
        r_sync1   <= key_in[g];
        r_sync2   <= r_sync1;
        r_press   <= w_flip && w_raw;
        r_release <= w_flip && !w_raw;
        r_long    <= w_hit && !w_flip;

        if ((w_raw == r_state) || w_flip) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end

        if (w_flip) begin
          r_state <= w_raw;
        end

        if (!r_state || w_flip) begin
          r_hold  <= '0;
          r_fired <= 1'b0;
        end else if (w_hit) begin
          r_hold  <= REPEAT_EN ? '0 : r_hold;
          r_fired <= 1'b1;
        end else if (!r_fired || REPEAT_EN) begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end

    assign key_state[g]   = r_state;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel key debouncer and event generator for the ALU demo boards.
- Per channel: synchronises an asynchronous key input and filters contact bounce.
- Emits a debounced level plus single-cycle press, release and long-press (optionally auto-repeat) pulses.
- Replaces per-key single-pulse filters; feeds operand-load and mode-select logic.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- ACTIVE_LEVEL, 1, pressed level of key_in (1 = active-high, 0 = active-low); applies to all channels.
- DURATION, 600, consecutive stable cycles required to accept a level change (>=2).
- CNT_WIDTH, 12, width of the debounce counter; must hold DURATION-1.
- LONG_DURATION, 50000000, cycles of debounced press before key_long fires.
- REPEAT_EN, 0, 1 = key_long re-fires every REPEAT_PERIOD cycles while held.
- REPEAT_PERIOD, 10000000, auto-repeat interval in cycles.
- LONG_WIDTH, 26, width of the hold counter; must hold max(LONG_DURATION, REPEAT_PERIOD)-1.

Ports:
- mclk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- key_in, input, NUM_KEYS, raw asynchronous key inputs.
- key_state, output, NUM_KEYS, debounced level; 1 = pressed, polarity already normalised.
- key_press, output, NUM_KEYS, 1-cycle pulse when key_state rises.
- key_release, output, NUM_KEYS, 1-cycle pulse when key_state falls.
- key_long, output, NUM_KEYS, 1-cycle long-press or repeat pulse.

Behaviour:
- Channels are fully independent; the description below applies per bit i.
- Synchroniser: 2-flop chain on key_in[i].
  - Reset value is the inactive level (~ACTIVE_LEVEL), so no press appears after reset.
  - raw = sync_out XNOR ACTIVE_LEVEL (raw = 1 means pressed).
- Debounce counter:
  - Clears to 0 whenever raw == key_state.
  - Otherwise increments by 1 per cycle.
  - On the edge where the counter == DURATION-1 and raw != key_state: key_state <= raw and the counter clears.
  - Any mismatch run shorter than DURATION cycles leaves key_state unchanged.
- Latency: key_in change to key_state change = 2 (sync) + DURATION cycles for a clean edge.
- Edge pulses:
  - key_press and key_release are registered.
  - Each is high exactly in the first cycle key_state shows its new value.
  - They are never asserted together on one channel.
- Hold counter:
  - Clears while key_state == 0.
  - While key_state == 1, increments each cycle.
  - When it reaches LONG_DURATION-1: key_long = 1 for one cycle.
  - REPEAT_EN = 0: the counter then saturates; no further key_long until release and re-press.
  - REPEAT_EN = 1: after the first key_long the counter reloads 0 and fires again every REPEAT_PERIOD cycles.
  - key_long is coincident with neither key_press nor key_release.
- Release during the hold phase: the counter clears and no key_long is issued.
  - A release in the same cycle the counter hits its threshold still fires key_long, because key_state changes only after DURATION cycles.
- Counters never wrap; parameter widths are sized so that overflow cannot occur.
- Reset, including mid-press: every output, counter and key_state returns to 0 on the next mclk edge.
  - A key held through reset must be re-debounced.
  - It then produces key_press DURATION+2 cycles after rst deasserts.
- Outputs are fully registered; no combinational path from key_in to any output.

Test Plan:
Bench parameters: NUM_KEYS=2, DURATION=4, LONG_DURATION=20, REPEAT_PERIOD=8, ACTIVE_LEVEL=1 unless stated.
- Clean press: key_in[0] 0->1 held -> key_state[0] rises and key_press[0]=1 for one cycle, 6 cycles after the input edge; key_release stays 0; channel 1 stays 0.
- Bounce rejection: key_in[0] toggles with 3-cycle high and 2-cycle low runs for 40 cycles -> no key_press and key_state[0]=0; once held high, key_press fires 6 cycles after the final rising edge. Release mirrors this with key_release.
- Long press, REPEAT_EN=0: hold 60 cycles after key_press -> exactly one key_long[0], 20 cycles after key_press; release gives key_release 6 cycles after the input falls.
- Auto-repeat, REPEAT_EN=1: hold 60 cycles -> key_long at +20, +28, +36, +44, +52 relative to key_press; none after release is accepted.
- Active-low build (ACTIVE_LEVEL=0): key_in idle at 1 through reset -> no pulses. Drive 0 for 10 cycles -> key_press after 6 cycles.
- Reset and simultaneity:
  - Assert rst for 1 cycle while key_state=1 -> all outputs 0 on the next cycle.
  - Key still held -> fresh key_press 6 cycles after rst drops.
  - Both channels pressed on the same cycle -> both key_press bits pulse together.
